pipe_stall_ctrl: RTL

Central hazard controller that drives the `stall_i` inputs and flush controls of every pipeline register in the RV32I five-stage core. It detects load-use hazards, taken-branch redirects and data-memory wait conditions, and sequences the required bubbles and flushes. Its multi-cycle sequencing accounts for the one-cycle read latency of the instruction and data SRAMs.

---
 rtl/pipe_stall_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard controller for the RV32I five-stage pipe: load-use bubbles, branch flushes, data-memory freeze.
// Optional build macro STALL_PERF_CNT_EN adds the stall/flush cycle counters.
module pipe_stall_ctrl #(
    parameter int LU_BUBBLES   = 2,
    parameter int BR_FLUSH_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        branch_taken_i,
    input  logic        mem_wait_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_USE  = 2'd1,
        ST_FLUSH     = 2'd2,
        ST_MEM_WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);
    localparam logic [1:0] BR_RELOAD = 2'(BR_FLUSH_CYC - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] cnt_r;
    logic [1:0] next_cnt_s;

    logic       hz_s;
    logic       pc_stall_s;
    logic       if_id_stall_s;
    logic       id_ex_stall_s;
    logic       ex_mem_stall_s;
    logic       mem_wb_stall_s;
    logic       if_id_flush_s;
    logic       id_ex_flush_s;

    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        logic hit;
        hit = (rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd));
        return mem_read && (rd != 5'd0) && hit;
    endfunction

    assign hz_s = load_use_hazard(id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
                                  ex_rd_i, ex_mem_read_i);

    // Next-state and Mealy output decode; freeze beats branch beats load-use beats sequencing.
    always_comb begin
        next_state_s   = state_r;
        next_cnt_s     = cnt_r;
        pc_stall_s     = 1'b0;
        if_id_stall_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        ex_mem_stall_s = 1'b0;
        mem_wb_stall_s = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;

        if (mem_wait_i) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            mem_wb_stall_s = 1'b1;
            if (state_r == ST_RUN) begin
                next_state_s = ST_MEM_WAIT;
            end else begin
                next_state_s = state_r;
            end
        end else if (branch_taken_i) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            if (BR_FLUSH_CYC > 1) begin
                next_state_s = ST_FLUSH;
                next_cnt_s   = BR_RELOAD;
            end else begin
                next_state_s = ST_RUN;
                next_cnt_s   = 2'd0;
            end
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (hz_s) begin
                        pc_stall_s    = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            next_state_s = ST_LOAD_USE;
                            next_cnt_s   = LU_RELOAD;
                        end else begin
                            next_state_s = ST_RUN;
                            next_cnt_s   = 2'd0;
                        end
                    end else begin
                        next_state_s = ST_RUN;
                        next_cnt_s   = 2'd0;
                    end
                end
                ST_LOAD_USE: begin
                    pc_stall_s    = 1'b1;
                    if_id_stall_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    if (cnt_r <= 2'd1) begin
                        next_state_s = ST_RUN;
                        next_cnt_s   = 2'd0;
                    end else begin
                        next_state_s = ST_LOAD_USE;
                        next_cnt_s   = cnt_r - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    // Drops the stale fetch word still returning from the instruction SRAM.
                    if_id_flush_s = 1'b1;
                    if (cnt_r <= 2'd1) begin
                        next_state_s = ST_RUN;
                        next_cnt_s   = 2'd0;
                    end else begin
                        next_state_s = ST_FLUSH;
                        next_cnt_s   = cnt_r - 2'd1;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                    next_cnt_s   = 2'd0;
                end
            endcase
        end
    end

    // Outputs are held low throughout reset regardless of the state decode.
    always_comb begin
        if (rst_i) begin
            pc_stall_o     = 1'b0;
            if_id_stall_o  = 1'b0;
            id_ex_stall_o  = 1'b0;
            ex_mem_stall_o = 1'b0;
            mem_wb_stall_o = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
        end else begin
            pc_stall_o     = pc_stall_s;
            if_id_stall_o  = if_id_stall_s;
            id_ex_stall_o  = id_ex_stall_s;
            ex_mem_stall_o = ex_mem_stall_s;
            mem_wb_stall_o = mem_wb_stall_s;
            if_id_flush_o  = if_id_flush_s;
            id_ex_flush_o  = id_ex_flush_s;
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running performance counters; they wrap rather than saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (pc_stall_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (if_id_flush_s || id_ex_flush_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_r;
    assign flush_cycles_o = flush_cnt_r;
`else
    assign stall_cycles_o = 32'h0;
    assign flush_cycles_o = 32'h0;
`endif

endmodule
